// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller for any integer depth, with level, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one registered cycle of latency.
module sync_fifo_ctrl #(
  parameter int BITS     = 32,
  parameter int SIZE     = 16,
  parameter int AF_LEVEL = SIZE - 2,
  parameter int AE_LEVEL = 2,
  parameter int LW       = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p_clear,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  output logic            p_write_almost_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_valid,
  output logic            p_read_empty,
  output logic            p_read_almost_empty,
  output logic [LW-1:0]   p_level,
  output logic            p_overflow,
  output logic            p_underflow
);

  localparam int            PW       = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(SIZE - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(SIZE);

  logic [BITS-1:0] mem [SIZE];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full, empty, wr_acc, rd_acc;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  // Acceptance uses the pre-edge level, so a full FIFO rejects a same-cycle write even when a read drains it.
  assign wr_acc = p_write_en && !full  && !p_clear;
  assign rd_acc = p_read_en  && !empty && !p_clear;

  assign p_write_full        = full;
  assign p_read_empty        = empty;
  assign p_write_almost_full = (level_q >= LW'(AF_LEVEL));
  assign p_read_almost_empty = (level_q <= LW'(AE_LEVEL));
  assign p_level             = level_q;
  assign p_overflow          = ovf_q;
  assign p_underflow         = udf_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (p_clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = next_ptr(wptr_q);
      if (rd_acc) rptr_d = next_ptr(rptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (p_write_en & full);
      udf_d = udf_q | (p_read_en & empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is never reset or flushed; only the pointers decide what is live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= p_write_data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // The head word is shown only while valid so the output is zero in reset and after a flush.
  assign p_read_valid = !empty;
  assign p_read_data  = empty ? '0 : mem[rptr_q];
`else
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d;

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (p_clear) begin
      rdata_d = '0;
    end else if (rd_acc) begin
      rdata_d  = mem[rptr_q];
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign p_read_data  = rdata_q;
  assign p_read_valid = rvalid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed plan steps followed by random traffic,
// all compared against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int BITS = 16;
  localparam int SIZE = 5;
  localparam int AF   = 4;
  localparam int AE   = 1;
  localparam int LW   = $clog2(SIZE + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            p_clear = 1'b0;
  logic            p_write_en = 1'b0;
  logic [BITS-1:0] p_write_data = '0;
  logic            p_read_en = 1'b0;
  logic            p_write_full, p_write_almost_full;
  logic [BITS-1:0] p_read_data;
  logic            p_read_valid, p_read_empty, p_read_almost_empty;
  logic [LW-1:0]   p_level;
  logic            p_overflow, p_underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [BITS-1:0] q[$];
  logic            m_ovf, m_udf, m_valid;
  logic [BITS-1:0] m_rdata;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.BITS(BITS), .SIZE(SIZE), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .p_clear(p_clear),
    .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(p_write_full), .p_write_almost_full(p_write_almost_full),
    .p_read_en(p_read_en), .p_read_data(p_read_data), .p_read_valid(p_read_valid),
    .p_read_empty(p_read_empty), .p_read_almost_empty(p_read_almost_empty),
    .p_level(p_level), .p_overflow(p_overflow), .p_underflow(p_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_rdata = '0;
  endtask

  // One clock edge of the reference: a FIFO as a queue, decisions taken on the pre-edge occupancy.
  task automatic model_edge(input logic we, input logic [BITS-1:0] wd, input logic re, input logic clr);
    int n;
    n = q.size();
    m_valid = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (we && n == SIZE) m_ovf = 1'b1;
      if (re && n == 0)    m_udf = 1'b1;
      if (re && n > 0) begin
        m_rdata = q.pop_front();
        m_valid = 1'b1;
      end
      if (we && n < SIZE) q.push_back(wd);
    end
  endtask

  task automatic check_all(input string ctx);
    int n;
    logic [BITS-1:0] exp_data;
    logic            exp_valid;
    n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
    exp_valid = (n > 0);
    exp_data  = (n > 0) ? q[0] : '0;
`else
    exp_valid = m_valid;
    exp_data  = m_rdata;
`endif
    chk({ctx, ".level"},  32'(p_level), 32'(n));
    chk({ctx, ".full"},   32'(p_write_full), 32'(n == SIZE));
    chk({ctx, ".empty"},  32'(p_read_empty), 32'(n == 0));
    chk({ctx, ".afull"},  32'(p_write_almost_full), 32'(n >= AF));
    chk({ctx, ".aempty"}, 32'(p_read_almost_empty), 32'(n <= AE));
    chk({ctx, ".ovf"},    32'(p_overflow), 32'(m_ovf));
    chk({ctx, ".udf"},    32'(p_underflow), 32'(m_udf));
    chk({ctx, ".valid"},  32'(p_read_valid), 32'(exp_valid));
    chk({ctx, ".rdata"},  32'(p_read_data), 32'(exp_data));
  endtask

  task automatic step(input string ctx, input logic we, input logic [BITS-1:0] wd,
                      input logic re, input logic clr);
    p_write_en = we; p_write_data = wd; p_read_en = re; p_clear = clr;
    @(posedge clk);
    model_edge(we, wd, re, clr);
    @(negedge clk);
    p_write_en = 1'b0; p_read_en = 1'b0; p_clear = 1'b0;
    $display("[%0t] %s we=%0b wd=%0h re=%0b clr=%0b -> level=%0d rdata=%0h valid=%0b",
             $time, ctx, we, wd, re, clr, p_level, p_read_data, p_read_valid);
    check_all(ctx);
  endtask

  initial begin
    model_reset();
    // Reset held with a write pending.
    p_write_en = 1'b1; p_write_data = 16'hDEAD;
    repeat (2) @(negedge clk);
    check_all("rst_hold");
    p_write_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("rst_rel");

    for (int i = 0; i < SIZE; i++) step("fill", 1'b1, 16'(16'hA0 + i), 1'b0, 1'b0);
    step("ovf_write", 1'b1, 16'hBB, 1'b0, 1'b0);
    for (int i = 0; i < SIZE; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("clr1", 1'b0, '0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) step("wrap_w", 1'b1, 16'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step("wrap_r", 1'b0, '0, 1'b1, 1'b0);
    end

    for (int i = 0; i < SIZE; i++) step("fill2", 1'b1, 16'(16'hC0 + i), 1'b0, 1'b0);
    step("rw_full", 1'b1, 16'hCC, 1'b1, 1'b0);
    step("clr2", 1'b0, '0, 1'b0, 1'b1);
    step("rw_empty", 1'b1, 16'hD0, 1'b1, 1'b0);
    step("w_lvl2", 1'b1, 16'hD1, 1'b0, 1'b0);
    step("rw_lvl2", 1'b1, 16'hD2, 1'b1, 1'b0);
    step("rd_a", 1'b0, '0, 1'b1, 1'b0);
    step("rd_b", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, 16'(16'hE0 + i), 1'b0, 1'b0);
    step("clr_w", 1'b1, 16'h77, 1'b0, 1'b1);
    step("w55", 1'b1, 16'h55, 1'b0, 1'b0);
    step("r55", 1'b0, '0, 1'b1, 1'b0);

    step("w1234", 1'b1, 16'h1234, 1'b0, 1'b0);
    step("r1234", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 99) < 55), 16'($urandom),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset asserted between edges during a burst.
    for (int i = 0; i < 3; i++) step("burst", 1'b1, 16'($urandom), 1'b0, 1'b0);
    p_write_en = 1'b1; p_read_en = 1'b1;
    @(posedge clk);
    model_edge(1'b1, p_write_data, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    p_write_en = 1'b0; p_read_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("async_rel");
    step("post_w", 1'b1, 16'h0F0F, 1'b0, 1'b0);
    step("post_r", 1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO with a parametrised data width and any integer depth, not only powers of two. It adds an occupancy level output, almost-full and almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is the same-clock counterpart of `async_fifo` and uses the same `p_` port set, so a bench can drive either block with the same write/read tasks.

## Interface
Parameters:
- BITS, 32, width of each entry (>= 1).
- SIZE, 16, number of entries (>= 2, any integer).
- AF_LEVEL, SIZE-2, almost-full threshold; legal range AE_LEVEL < AF_LEVEL <= SIZE.
- AE_LEVEL, 2, almost-empty threshold; legal range 0 <= AE_LEVEL < AF_LEVEL.
- LW, $clog2(SIZE+1), width of the level port (derived; do not override).

Ports:
- clk  in  1  the block's only clock; every register updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- p_clear  in  1  synchronous flush.
- p_write_en  in  1  write request.
- p_write_data  in  BITS  data to write.
- p_write_full  out  1  FIFO full.
- p_write_almost_full  out  1  level >= AF_LEVEL.
- p_read_en  in  1  read request.
- p_read_data  out  BITS  read data.
- p_read_valid  out  1  p_read_data holds a valid entry.
- p_read_empty  out  1  FIFO empty.
- p_read_almost_empty  out  1  level <= AE_LEVEL.
- p_level  out  LW  current occupancy, 0..SIZE.
- p_overflow  out  1  sticky: a write was attempted while full.
- p_underflow  out  1  sticky: a read was attempted while empty.

## Operation
- State: write pointer, read pointer (each 0..SIZE-1), level register (0..SIZE), storage array mem[SIZE], sticky flags, and, in standard mode only, the read-data and read-valid registers.
- Every status output is decoded from the level register only:
  - full = (level == SIZE)
  - empty = (level == 0)
  - almost_full = (level >= AF_LEVEL)
  - almost_empty = (level <= AE_LEVEL)
- Write accepted: p_write_en && !p_write_full. Stores to mem[wptr]; wptr advances, wrapping SIZE-1 -> 0 (explicit compare, not modulo-2^n).
- Read accepted: p_read_en && !p_read_empty. rptr advances with the same wrap rule.
- Level update per cycle:
  - +1 on write only.
  - -1 on read only.
  - unchanged when both are accepted or neither is.
- Full FIFO with simultaneous read and write: the write is rejected, because full is evaluated from the pre-edge state. Only the read happens; level becomes SIZE-1.
- Empty FIFO with simultaneous read and write: the read is rejected; only the write happens.
- p_overflow sets when p_write_en && p_write_full. p_underflow sets when p_read_en && p_read_empty. Both hold until p_clear or reset.
- p_clear has priority over everything else:
  - pointers and level go to 0;
  - sticky flags, p_read_data and p_read_valid are cleared;
  - a read or write in the same cycle is ignored and does not set an error flag.
  - Storage contents are not cleared.
- Reset (rst_n low, at any time, including mid-burst) drives the same state as p_clear, asynchronously. Output values during reset:
  - p_read_empty = 1, p_read_almost_empty = 1
  - p_write_full = 0, p_write_almost_full = 0
  - p_level = 0, p_read_data = 0, p_read_valid = 0
  - p_overflow = 0, p_underflow = 0

## Timing
- Status outputs reflect the new level in the cycle after the edge that accepts an access.
- Write-to-read latency: a write accepted at edge N makes p_read_empty = 0 after edge N; the earliest accepted read is at edge N+1.
- Standard mode:
  - p_read_data is registered and loaded with mem[rptr] on an accepted read at edge N.
  - p_read_valid = 1 for the cycle after edge N, otherwise 0.
  - p_read_data holds its value when there is no accepted read.
- Back-to-back accesses sustain one write and one read per cycle with no bubbles.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - p_read_data = mem[rptr] combinationally.
  - p_read_valid = !p_read_empty.
  - p_read_en acknowledges the displayed word; no read-data register exists.
  - The head word is visible in the cycle after the write that made the FIFO non-empty.
- SYNC_FIFO_FWFT_EN undefined: standard mode, with the registered one-cycle read latency described under Timing.

## Test plan
- SIZE=5, AF_LEVEL=4, AE_LEVEL=1: reset with writes pending -> after release, empty=1, almost_empty=1, level=0, full=0, read_data=0.
- SIZE=5: write 0xA0..0xA4 -> level=5, full=1, almost_full after the 4th write; a 6th write sets p_overflow and is dropped; reading 5 returns 0xA0..0xA4 in order.
- SIZE=5 wrap-around: write 3 / read 3 repeated 4 times (pointers cross SIZE-1 -> 0) -> data returned in order, level back to 0, no error flags set.
- Simultaneous read and write at level 5 -> level 4, p_overflow set; at level 0 -> level 1, p_underflow set; at level 2 -> level stays 2, data order preserved.
- p_clear at level 3 with p_write_en=1 in the same cycle -> level=0, empty=1, sticky flags 0, no write stored; the next write/read of 0x55 returns 0x55.
- Both modes: write 0x1234 at edge N. FWFT: p_read_data=0x1234 and p_read_valid=1 after edge N. Standard: read at edge N+1, then p_read_valid=1 and p_read_data=0x1234 after edge N+1.
